// File: rtl/add_sub_arbiter_pkg.sv
// Shared definitions for the two-requester add/sub arbiter: FSM encoding,
// operation codes and the round-robin grant helper.
package add_sub_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One-hot grant; on a tie the requester not granted last time wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last);
        logic [1:0] grant;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/Full_Adder_Sub.sv
// Ripple add/subtract datapath: Cin = 1 selects A - B (two's complement),
// Cout is the raw carry out of the top bit.
module Full_Adder_Sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff     = B ^ {WIDTH{Cin}};
    assign {Cout, Sum} = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, Cin};

endmodule

// File: rtl/add_sub_arbiter.sv
// Two requesters share one add/sub datapath through an IDLE/CALC/RESP FSM
// with round-robin arbitration and a valid/ready response channel.
module add_sub_arbiter
    import add_sub_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [1:0]         Req_Valid,
    output logic [1:0]         Req_Ready,
    input  logic [2*WIDTH-1:0] Req_A,
    input  logic [2*WIDTH-1:0] Req_B,
    input  logic [1:0]         Req_Op,
    output logic               Rsp_Valid,
    input  logic               Rsp_Ready,
    output logic [WIDTH-1:0]   Rsp_Sum,
    output logic               Rsp_Cout,
    output logic               Rsp_Id
);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       w_grant;
    logic             w_grant_id;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_id;
    logic             r_last;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_rsp_id;
    logic             r_rsp_valid;

    // Next-state and grant decode; grants are only offered in IDLE out of reset.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (RST) begin
                    w_grant = rr_grant(Req_Valid, r_last);
                end else begin
                    w_grant = 2'b00;
                end
                if (|w_grant) begin
                    w_next_state = ST_CALC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: w_next_state = ST_RESP;
            ST_RESP: begin
                if (Rsp_Ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign Req_Ready  = w_grant;
    assign w_grant_id = w_grant[1];
    assign w_a_sel    = w_grant_id ? Req_A[2*WIDTH-1:WIDTH] : Req_A[WIDTH-1:0];
    assign w_b_sel    = w_grant_id ? Req_B[2*WIDTH-1:WIDTH] : Req_B[WIDTH-1:0];

    Full_Adder_Sub #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .A    (r_a),
        .B    (r_b),
        .Cin  (r_op),
        .Sum  (w_sum),
        .Cout (w_carry)
    );

    // State, operand capture and result registers; reset drops any in-flight op.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_op        <= OP_ADD;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_sum       <= {WIDTH{1'b0}};
            r_cout      <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_a    <= w_a_sel;
                        r_b    <= w_b_sel;
                        r_op   <= Req_Op[w_grant_id];
                        r_id   <= w_grant_id;
                        r_last <= w_grant_id;
                    end
                end
                ST_CALC: begin
                    r_sum       <= w_sum;
                    // Subtract reports borrow, which is the inverted carry.
                    r_cout      <= (r_op == OP_SUB) ? ~w_carry : w_carry;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (Rsp_Ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign Rsp_Valid = r_rsp_valid;
    assign Rsp_Sum   = r_sum;
    assign Rsp_Cout  = r_cout;
    assign Rsp_Id    = r_rsp_id;

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed self-checking bench for add_sub_arbiter at WIDTH = 8.
module tb_add_sub_arbiter;

    localparam int WIDTH = 8;

    logic               CLK;
    logic               RST;
    logic [1:0]         Req_Valid;
    logic [1:0]         Req_Ready;
    logic [2*WIDTH-1:0] Req_A;
    logic [2*WIDTH-1:0] Req_B;
    logic [1:0]         Req_Op;
    logic               Rsp_Valid;
    logic               Rsp_Ready;
    logic [WIDTH-1:0]   Rsp_Sum;
    logic               Rsp_Cout;
    logic               Rsp_Id;

    int n_cmp = 0;
    int n_err = 0;

    add_sub_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_A     (Req_A),
        .Req_B     (Req_B),
        .Req_Op    (Req_Op),
        .Rsp_Valid (Rsp_Valid),
        .Rsp_Ready (Rsp_Ready),
        .Rsp_Sum   (Rsp_Sum),
        .Rsp_Cout  (Rsp_Cout),
        .Rsp_Id    (Rsp_Id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one request, check grant, then check CALC and RESP cycles and
    // complete the handshake (Rsp_Ready held high).
    task automatic run_one(input string tag, input logic [1:0] valid, input logic [1:0] exp_ready,
                           input logic [7:0] exp_sum, input logic exp_cout, input logic exp_id);
        Req_Valid = valid;
        Rsp_Ready = 1'b1;
        #1;
        chk({tag, "_grant"}, {14'd0, Req_Ready}, {14'd0, exp_ready});
        step();
        Req_Valid = 2'b00;
        #1;
        chk({tag, "_calc_valid"}, {15'd0, Rsp_Valid}, 16'd0);
        chk({tag, "_calc_ready"}, {14'd0, Req_Ready}, 16'd0);
        step();
        chk({tag, "_rsp_valid"}, {15'd0, Rsp_Valid}, 16'd1);
        chk({tag, "_sum"},  {8'd0, Rsp_Sum},  {8'd0, exp_sum});
        chk({tag, "_cout"}, {15'd0, Rsp_Cout}, {15'd0, exp_cout});
        chk({tag, "_id"},   {15'd0, Rsp_Id},   {15'd0, exp_id});
        step();
        chk({tag, "_done"}, {15'd0, Rsp_Valid}, 16'd0);
    endtask

    initial begin
        RST       = 1'b0;
        Req_Valid = 2'b11;
        Req_A     = 16'h0000;
        Req_B     = 16'h0000;
        Req_Op    = 2'b00;
        Rsp_Ready = 1'b0;

        // Reset state, with requests pending that must not be granted.
        step();
        step();
        chk("rst_ready", {14'd0, Req_Ready}, 16'd0);
        chk("rst_valid", {15'd0, Rsp_Valid}, 16'd0);
        chk("rst_sum",   {8'd0, Rsp_Sum},    16'd0);
        chk("rst_cout",  {15'd0, Rsp_Cout},  16'd0);
        chk("rst_id",    {15'd0, Rsp_Id},    16'd0);
        Req_Valid = 2'b00;
        RST = 1'b1;
        step();

        // Basic arithmetic vectors.
        Req_A = {8'h3B, 8'h0A}; Req_B = {8'h65, 8'h05}; Req_Op = 2'b10;
        run_one("add0", 2'b01, 2'b01, 8'h0F, 1'b0, 1'b0);
        run_one("sub1", 2'b10, 2'b10, 8'hD6, 1'b1, 1'b1);
        Req_A = {8'h00, 8'hFF}; Req_B = {8'h00, 8'h01}; Req_Op = 2'b00;
        run_one("addwrap", 2'b01, 2'b01, 8'h00, 1'b1, 1'b0);
        Req_A = {8'h00, 8'h05}; Req_B = {8'h00, 8'h05}; Req_Op = 2'b01;
        run_one("subeq", 2'b01, 2'b01, 8'h00, 1'b0, 1'b0);

        // Re-reset so the tie pointer restarts, then both valid continuously.
        RST = 1'b0;
        step();
        RST = 1'b1;
        Req_A = {8'h20, 8'h10}; Req_B = {8'h02, 8'h01}; Req_Op = 2'b10;
        run_one("rr0", 2'b11, 2'b01, 8'h11, 1'b0, 1'b0);
        run_one("rr1", 2'b11, 2'b10, 8'h1E, 1'b0, 1'b1);
        run_one("rr2", 2'b11, 2'b01, 8'h11, 1'b0, 1'b0);
        run_one("rr3", 2'b11, 2'b10, 8'h1E, 1'b0, 1'b1);

        // Back-pressure: response held while consumer stalls; requests ignored.
        Req_A = {8'h80, 8'h00}; Req_B = {8'h80, 8'h00}; Req_Op = 2'b00;
        Req_Valid = 2'b10;
        Rsp_Ready = 1'b0;
        #1;
        chk("bp_grant", {14'd0, Req_Ready}, 16'h0002);
        step();
        Req_Valid = 2'b11;
        Req_A = 16'hFFFF; Req_Op = 2'b11;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {15'd0, Rsp_Valid}, 16'd1);
            chk("bp_sum",   {8'd0, Rsp_Sum},    16'h0000);
            chk("bp_cout",  {15'd0, Rsp_Cout},  16'd1);
            chk("bp_id",    {15'd0, Rsp_Id},    16'd1);
            chk("bp_ready", {14'd0, Req_Ready}, 16'd0);
            step();
        end
        Req_Valid = 2'b00;
        Rsp_Ready = 1'b1;
        step();
        chk("bp_done", {15'd0, Rsp_Valid}, 16'd0);

        // Reset during CALC discards the operation; tie then goes to requester 0.
        Req_A = {8'h00, 8'h33}; Req_B = {8'h00, 8'h44}; Req_Op = 2'b00;
        Req_Valid = 2'b01;
        #1;
        chk("rc_grant", {14'd0, Req_Ready}, 16'h0001);
        step();
        Req_Valid = 2'b00;
        RST = 1'b0;
        step();
        chk("rc_valid", {15'd0, Rsp_Valid}, 16'd0);
        chk("rc_ready", {14'd0, Req_Ready}, 16'd0);
        RST = 1'b1;
        Req_Valid = 2'b11;
        #1;
        chk("rc_tie", {14'd0, Req_Ready}, 16'h0001);
        Req_Valid = 2'b00;
        step();
        step();
        chk("rc_norsp", {15'd0, Rsp_Valid}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
